mult_booth: RTL
===============

Name: mult_booth

Overview:
- Multicycle signed 32x32 multiplier using radix-2 Booth recoding; executes MULT and produces a 64-bit product split into HI and LO.
- Sits directly upstream of the 5-input 32-bit data-select mux. output_hi and output_lo feed two of that mux's inputs, which carry MFHI/MFLO write-back data.
- The control FSM pulses start, then waits for done before selecting HI/LO through the mux.

Parameters:
- DATA_WIDTH, 32, operand width; product is 2*DATA_WIDTH.
- CNT_WIDTH, 6, iteration-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH+1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  start request; sampled only in IDLE.
- input_a  input  32  multiplicand (signed); captured on accepted start.
- input_b  input  32  multiplier (signed); captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- output_hi  output  32  product[63:32].
- output_lo  output  32  product[31:0].

Behaviour:
- Reset: when reset_n=0 at a clk edge, the following are forced, overriding any other event that cycle:
  - state=IDLE; busy=0; done=0; output_hi=0; output_lo=0.
  - Internal A, Q, q_m1 and count are cleared to 0.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - On start=1, capture M={input_a[31],input_a} (33-bit sign-extended), Q=input_b, A=0 (33 bits), q_m1=0, count=0.
  - Transition to RUN. start=0 stays in IDLE.
- RUN: one Booth step per cycle.
  - {Q[0],q_m1}=01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged. All arithmetic is 33-bit.
  - After the add/sub, arithmetic-shift {A,Q,q_m1} right by 1, replicating A[32].
  - count increments each step. After the step where count==31 (32 steps total), go to FINISH.
- FINISH (one cycle):
  - Load output_hi=A[31:0] and output_lo=Q, assert done=1, go to IDLE.
- Latency: start sampled at edge 0; busy=1 for edges 1..32; done=1 and outputs valid in the cycle after edge 33. Back-to-back ops: a new start is accepted in the IDLE cycle after FINISH.
- The 33-bit A absorbs overflow when M=-2^31 (A-M case); the result for 0x80000000*0x80000000 is exact.
- start during RUN/FINISH: ignored; no queuing, no effect on the operation in flight.
- Operand inputs may change freely after acceptance.
- output_hi/output_lo hold the last result until the next FINISH or reset. They do not change during RUN.
- done is never asserted together with busy.

Optional Feature:
- Macro: MULT_UNSIGNED_EN.
- Defined:
  - Adds port is_unsigned (input, 1), captured with the operands on start.
  - When is_unsigned=1, operands are zero-extended: M={1'b0,input_a}, Q={1'b0,input_b}, 33 bits each, with A at 34 bits. RUN executes 33 steps, so done comes one cycle later. The product is the low 64 bits of {A,Q}. Supports MULTU.
  - When is_unsigned=0, timing and results are identical to the undefined case.
- Undefined:
  - No is_unsigned port; always signed, 32 steps.

Decomposition:
- Package mult_pkg:
  - State enum mult_state_t {IDLE, RUN, FINISH}.
  - Localparams: MULT_STEPS_SIGNED=32, MULT_STEPS_UNSIGNED=33, PROD_WIDTH=64.
- Sub-module booth_step (combinational):
  - Inputs: A, Q, q_m1, M.
  - Output: next {A,Q,q_m1}.
  - Keeps the arithmetic separate from the FSM and is unit-testable on its own.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles -> busy=0, done=0, output_hi=output_lo=0x00000000.
- Signed mixed: a=7, b=-3 (0xFFFFFFFD), start -> done exactly 34 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Boundary: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=b=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001.
- Start while busy: start a=3, b=5; pulse start with a=9, b=9 at RUN cycle 10 -> single done pulse, hi=0, lo=15; the second request is dropped.
- Reset mid-operation: start a=100, b=200; reset_n=0 at RUN cycle 16 -> next cycle busy=0, outputs 0, no done pulse. A fresh start of 2*3 then gives lo=6.
- (MULT_UNSIGNED_EN) is_unsigned=1, a=b=0xFFFFFFFF -> done after 35 cycles, hi=0xFFFFFFFE, lo=0x00000001. The same operands with is_unsigned=0 give hi=0, lo=1.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } mult_state_t;

    localparam int MULT_STEPS_SIGNED   = 32;
    localparam int MULT_STEPS_UNSIGNED = 33;
    localparam int PROD_WIDTH          = 64;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of the {A,Q,q_m1} chain.
module booth_step #(
    parameter int A_WIDTH = 33,
    parameter int Q_WIDTH = 32
) (
    input  logic [A_WIDTH-1:0] a,
    input  logic [Q_WIDTH-1:0] q,
    input  logic               q_m1,
    input  logic [A_WIDTH-1:0] m,
    output logic [A_WIDTH-1:0] a_next,
    output logic [Q_WIDTH-1:0] q_next,
    output logic               q_m1_next
);

    logic [A_WIDTH-1:0] sum;

    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        sum = a;
        unique case ({q[0], q_m1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        // NOTE: blocking assignments here because this is combinational; registers use <=.
        {a_next, q_next, q_m1_next} = {sum[A_WIDTH-1], sum, q};
    end

endmodule

// File: rtl/mult_booth.sv
// Multicycle signed 32x32 Booth multiplier with registered HI/LO result.
// Define MULT_UNSIGNED_EN to add the is_unsigned port (MULTU, 33 steps).
module mult_booth
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] input_a,
    input  logic [DATA_WIDTH-1:0] input_b,
`ifdef MULT_UNSIGNED_EN
    input  logic                  is_unsigned,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] output_hi,
    output logic [DATA_WIDTH-1:0] output_lo
);

    localparam logic [CNT_WIDTH-1:0] LAST_SIGNED = CNT_WIDTH'(MULT_STEPS_SIGNED - 1);

`ifdef MULT_UNSIGNED_EN
    // Zero-extended operands need one extra guard bit in both A and Q.
    localparam int A_WIDTH = DATA_WIDTH + 2;
    localparam int Q_WIDTH = DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_UNSIGNED = CNT_WIDTH'(MULT_STEPS_UNSIGNED - 1);
`else
    localparam int A_WIDTH = DATA_WIDTH + 1;
    localparam int Q_WIDTH = DATA_WIDTH;
`endif

    mult_state_t           state;
    logic [A_WIDTH-1:0]    a_reg;
    logic [A_WIDTH-1:0]    m_reg;
    logic [Q_WIDTH-1:0]    q_reg;
    logic                  q_m1;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  last_count;

    logic [A_WIDTH-1:0]    a_next;
    logic [Q_WIDTH-1:0]    q_next;
    logic                  q_m1_next;
    logic [A_WIDTH-1:0]    load_m;
    logic [Q_WIDTH-1:0]    load_q;
    logic [PROD_WIDTH-1:0] product;

`ifdef MULT_UNSIGNED_EN
    logic unsigned_op;

    always_comb begin
        load_m = is_unsigned ? {2'b00, input_a}
                             : {{2{input_a[DATA_WIDTH-1]}}, input_a};
        load_q = is_unsigned ? {1'b0, input_b}
                             : {input_b[DATA_WIDTH-1], input_b};
        last_count = unsigned_op ? LAST_UNSIGNED : LAST_SIGNED;
        // Signed mode runs 32 steps on a 33-bit Q, leaving the unused sign bit in Q[0].
        if (unsigned_op)
            product = {a_reg[DATA_WIDTH-2:0], q_reg};
        else
            product = {a_reg[DATA_WIDTH-1:0], q_reg[DATA_WIDTH:1]};
    end
`else
    always_comb begin
        load_m     = {input_a[DATA_WIDTH-1], input_a};
        load_q     = input_b;
        last_count = LAST_SIGNED;
        product    = {a_reg[DATA_WIDTH-1:0], q_reg};
    end
`endif

    booth_step #(
        .A_WIDTH(A_WIDTH),
        .Q_WIDTH(Q_WIDTH)
    ) u_step (
        .a        (a_reg),
        .q        (q_reg),
        .q_m1     (q_m1),
        .m        (m_reg),
        .a_next   (a_next),
        .q_next   (q_next),
        .q_m1_next(q_m1_next)
    );

    // NOTE: the multiplicand is pure datapath, written before it is ever read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            m_reg <= load_m;
`ifdef MULT_UNSIGNED_EN
            unsigned_op <= is_unsigned;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            output_hi <= '0;
            output_lo <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            q_m1      <= 1'b0;
            count     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= '0;
                        q_reg <= load_q;
                        q_m1  <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_m1  <= q_m1_next;
                    count <= count + CNT_WIDTH'(1);
                    if (count == last_count) begin
                        busy  <= 1'b0;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    output_hi <= product[PROD_WIDTH-1:DATA_WIDTH];
                    output_lo <= product[DATA_WIDTH-1:0];
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
